// File: rtl/uart_recv.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling driven by one
// baud counter, registered one-cycle uart_en / frame_err pulses.
module uart_recv #(
   parameter int CLK_FREQ = 50000000,
   parameter int UART_BPS = 115200
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       uart_rxd,
   output logic [7:0] uart_data,
   output logic       uart_en,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
   localparam int HALF_CNT = BPS_CNT / 2;
   localparam int CW       = $clog2(BPS_CNT) + 1;
   localparam logic [CW-1:0] BPS_LAST  = CW'(BPS_CNT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic            sync1_r;
   logic            rxd_s;
   logic            rxd_d_r;
   logic            start_edge_s;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_nxt_s;
   logic [2:0]      idx_r;
   logic [2:0]      idx_nxt_s;
   logic [7:0]      shift_r;
   logic [7:0]      shift_nxt_s;
   logic [7:0]      data_nxt_s;
   logic            en_nxt_s;
   logic            err_nxt_s;

   assign start_edge_s = rxd_d_r & ~rxd_s;

   // Next-state and datapath updates; the line is only looked at on scheduled samples.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      idx_nxt_s   = idx_r;
      shift_nxt_s = shift_r;
      data_nxt_s  = uart_data;
      en_nxt_s    = 1'b0;
      err_nxt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_nxt_s = {CW{1'b0}};
            idx_nxt_s = 3'd0;
            if (start_edge_s) begin
               state_nxt_s = START;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (cnt_r == HALF_LAST) begin
               cnt_nxt_s = {CW{1'b0}};
               if (rxd_s == 1'b0) begin
                  state_nxt_s = DATA;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               cnt_nxt_s = cnt_r + 1'b1;
            end
         end
         DATA: begin
            if (cnt_r == BPS_LAST) begin
               cnt_nxt_s          = {CW{1'b0}};
               shift_nxt_s[idx_r] = rxd_s;
               idx_nxt_s          = idx_r + 3'd1;
               if (idx_r == 3'd7) begin
                  state_nxt_s = STOP;
               end else begin
                  state_nxt_s = DATA;
               end
            end else begin
               cnt_nxt_s = cnt_r + 1'b1;
            end
         end
         STOP: begin
            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
            if (cnt_r == BPS_LAST) begin
               cnt_nxt_s   = {CW{1'b0}};
               idx_nxt_s   = 3'd0;
               state_nxt_s = IDLE;
               if (rxd_s == 1'b1) begin
                  data_nxt_s = shift_r;
                  en_nxt_s   = 1'b1;
               end else begin
                  err_nxt_s  = 1'b1;
               end
            end else begin
               cnt_nxt_s = cnt_r + 1'b1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CW{1'b0}};
            idx_nxt_s   = 3'd0;
         end
      endcase
   end

   // All state, synchronizer and output registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1_r   <= 1'b1;
         rxd_s     <= 1'b1;
         rxd_d_r   <= 1'b1;
         state_r   <= IDLE;
         cnt_r     <= {CW{1'b0}};
         idx_r     <= 3'd0;
         shift_r   <= 8'h00;
         uart_data <= 8'h00;
         uart_en   <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         sync1_r   <= uart_rxd;
         rxd_s     <= sync1_r;
         rxd_d_r   <= rxd_s;
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         idx_r     <= idx_nxt_s;
         shift_r   <= shift_nxt_s;
         uart_data <= data_nxt_s;
         uart_en   <= en_nxt_s;
         frame_err <= err_nxt_s;
         rx_busy   <= (state_nxt_s != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv at 16 clocks per bit; expected bytes and
// error counts come from a frame-level model fed by the stimulus tasks.
module tb_uart_recv;

   localparam int CLK_FREQ = 16;
   localparam int UART_BPS = 1;
   localparam int B        = CLK_FREQ / UART_BPS;
   localparam int H        = B / 2;
   localparam int LAT      = 2 + H + 9 * B + 1;

   logic       sys_clk  = 1'b0;
   logic       sys_rst  = 1'b1;
   logic       uart_rxd = 1'b1;
   logic [7:0] uart_data;
   logic       uart_en;
   logic       frame_err;
   logic       rx_busy;

   uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .uart_rxd  (uart_rxd),
      .uart_data (uart_data),
      .uart_en   (uart_en),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   always #5 sys_clk = ~sys_clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // monitor state (written only by the monitor process)
   int         cyc = 0;
   int         en_cnt = 0;
   int         err_cnt = 0;
   int         both_cnt = 0;
   int         wide_cnt = 0;
   int         last_en_cyc = 0;
   logic       en_prev = 1'b0;
   logic       err_prev = 1'b0;
   logic [7:0] got_q[$];

   // reference model state (written only by the stimulus process)
   logic [7:0] exp_q[$];
   int         exp_err = 0;
   logic [7:0] last_good = 8'h00;
   int         frame_start_cyc = 0;
   int         en_base, err_base, got_base;

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (uart_en) begin
         en_cnt++;
         got_q.push_back(uart_data);
         last_en_cyc = cyc;
      end
      if (frame_err) err_cnt++;
      if (uart_en && frame_err) both_cnt++;
      if ((uart_en && en_prev) || (frame_err && err_prev)) wide_cnt++;
      en_prev  = uart_en;
      err_prev = frame_err;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic start_test();
      exp_q.delete();
      exp_err  = 0;
      en_base  = en_cnt;
      err_base = err_cnt;
      got_base = got_q.size();
   endtask

   // Drives one 8N1 frame; rst_bit >= 0 pulses sys_rst inside that data bit.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      frame_start_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         uart_rxd = bits[i];
         for (int c = 0; c < B; c++) begin
            if (rst_bit >= 0 && i == rst_bit + 1 && c == 4) sys_rst = 1'b1;
            if (rst_bit >= 0 && i == rst_bit + 1 && c == 7) sys_rst = 1'b0;
            @(negedge sys_clk);
         end
      end
      uart_rxd = 1'b1;
      if (rst_bit >= 0) begin
         last_good = 8'h00;
      end else if (stop) begin
         exp_q.push_back(b);
         last_good = b;
      end else begin
         exp_err++;
      end
   endtask

   task automatic test_reset();
      @(negedge sys_clk);
      sys_rst = 1'b1;
      uart_rxd = 1'b1;
      idle(3);
      chk_cnt++; if (uart_data !== 8'h00) $display("FAIL reset_data: got %h expected %h", uart_data, 8'h00); else pass_cnt++;
      chk_cnt++; if (uart_en !== 1'b0) $display("FAIL reset_en: got %b expected 0", uart_en); else pass_cnt++;
      chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", frame_err); else pass_cnt++;
      chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", rx_busy); else pass_cnt++;
      sys_rst = 1'b0;
      last_good = 8'h00;
      idle(5);
      chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", rx_busy); else pass_cnt++;
   endtask

   task automatic test_single();
      logic busy_mid;
      int   lat;
      start_test();
      busy_mid = 1'b0;
      fork
         send_frame(8'hA5, 1'b1, -1);
         begin idle(40); busy_mid = rx_busy; end
      join
      idle(4);
      lat = last_en_cyc - frame_start_cyc;
      chk_cnt++; if (busy_mid !== 1'b1) $display("FAIL single_busy_mid: got %b expected 1", busy_mid); else pass_cnt++;
      chk_cnt++; if (en_cnt - en_base != 1) $display("FAIL single_en_count: got %0d expected 1", en_cnt - en_base); else pass_cnt++;
      chk_cnt++; if (err_cnt - err_base != 0) $display("FAIL single_err_count: got %0d expected 0", err_cnt - err_base); else pass_cnt++;
      chk_cnt++; if (uart_data !== exp_q[0]) $display("FAIL single_data: got %h expected %h", uart_data, exp_q[0]); else pass_cnt++;
      chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL single_busy_after: got %b expected 0", rx_busy); else pass_cnt++;
      chk_cnt++; if (lat < LAT - 1 || lat > LAT + 1) $display("FAIL single_latency: got %0d expected %0d+-1", lat, LAT); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      start_test();
      send_frame(8'h3C, 1'b1, -1);
      send_frame(8'hC3, 1'b1, -1);
      idle(4);
      chk_cnt++; if (en_cnt - en_base != 2) $display("FAIL b2b_en_count: got %0d expected 2", en_cnt - en_base); else pass_cnt++;
      chk_cnt++;
      if (got_q.size() < got_base + 2) $display("FAIL b2b_first: got %0d bytes expected 2", got_q.size() - got_base);
      else if (got_q[got_base] !== 8'h3C) $display("FAIL b2b_first: got %h expected %h", got_q[got_base], 8'h3C);
      else pass_cnt++;
      chk_cnt++;
      if (got_q.size() < got_base + 2) $display("FAIL b2b_second: got %0d bytes expected 2", got_q.size() - got_base);
      else if (got_q[got_base+1] !== 8'hC3) $display("FAIL b2b_second: got %h expected %h", got_q[got_base+1], 8'hC3);
      else pass_cnt++;
      chk_cnt++; if (err_cnt - err_base != 0) $display("FAIL b2b_err_count: got %0d expected 0", err_cnt - err_base); else pass_cnt++;
   endtask

   task automatic test_glitch();
      logic busy_mid;
      start_test();
      uart_rxd = 1'b0;
      idle(4);
      uart_rxd = 1'b1;
      idle(2);
      busy_mid = rx_busy;
      idle(30);
      chk_cnt++; if (busy_mid !== 1'b1) $display("FAIL glitch_busy_mid: got %b expected 1", busy_mid); else pass_cnt++;
      chk_cnt++; if (en_cnt - en_base != 0) $display("FAIL glitch_en_count: got %0d expected 0", en_cnt - en_base); else pass_cnt++;
      chk_cnt++; if (err_cnt - err_base != 0) $display("FAIL glitch_err_count: got %0d expected 0", err_cnt - err_base); else pass_cnt++;
      chk_cnt++; if (uart_data !== last_good) $display("FAIL glitch_data: got %h expected %h", uart_data, last_good); else pass_cnt++;
      chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL glitch_busy_after: got %b expected 0", rx_busy); else pass_cnt++;
   endtask

   task automatic test_frame_err();
      sys_rst = 1'b1;
      idle(3);
      sys_rst = 1'b0;
      last_good = 8'h00;
      idle(4);
      start_test();
      send_frame(8'h55, 1'b0, -1);
      idle(8);
      chk_cnt++; if (err_cnt - err_base != exp_err) $display("FAIL ferr_err_count: got %0d expected %0d", err_cnt - err_base, exp_err); else pass_cnt++;
      chk_cnt++; if (en_cnt - en_base != 0) $display("FAIL ferr_en_count: got %0d expected 0", en_cnt - en_base); else pass_cnt++;
      chk_cnt++; if (uart_data !== last_good) $display("FAIL ferr_data: got %h expected %h", uart_data, last_good); else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      start_test();
      send_frame(8'hFF, 1'b1, 4);
      idle(10);
      chk_cnt++; if (en_cnt - en_base != 0) $display("FAIL rstmid_no_en: got %0d expected 0", en_cnt - en_base); else pass_cnt++;
      send_frame(8'h81, 1'b1, -1);
      idle(4);
      chk_cnt++; if (en_cnt - en_base != 1) $display("FAIL rstmid_en_count: got %0d expected 1", en_cnt - en_base); else pass_cnt++;
      chk_cnt++; if (err_cnt - err_base != 0) $display("FAIL rstmid_err_count: got %0d expected 0", err_cnt - err_base); else pass_cnt++;
      chk_cnt++; if (uart_data !== 8'h81) $display("FAIL rstmid_data: got %h expected %h", uart_data, 8'h81); else pass_cnt++;
   endtask

   task automatic test_break();
      start_test();
      uart_rxd = 1'b0;
      idle(40 * B);
      uart_rxd = 1'b1;
      exp_err = 1;
      chk_cnt++; if (err_cnt - err_base != exp_err) $display("FAIL break_err_during: got %0d expected %0d", err_cnt - err_base, exp_err); else pass_cnt++;
      idle(2 * B);
      send_frame(8'h01, 1'b1, -1);
      idle(4);
      chk_cnt++; if (err_cnt - err_base != exp_err) $display("FAIL break_err_count: got %0d expected %0d", err_cnt - err_base, exp_err); else pass_cnt++;
      chk_cnt++; if (en_cnt - en_base != 1) $display("FAIL break_en_count: got %0d expected 1", en_cnt - en_base); else pass_cnt++;
      chk_cnt++; if (uart_data !== 8'h01) $display("FAIL break_data: got %h expected %h", uart_data, 8'h01); else pass_cnt++;
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       stop;
      int         gap;
      start_test();
      for (int f = 0; f < 16; f++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0) && (f != 5);
         send_frame(b, stop, -1);
         gap = $urandom_range(0, 12);
         if (!stop && gap < 3) gap = 3;
         idle(gap);
      end
      idle(4);
      chk_cnt++; if (en_cnt - en_base != exp_q.size()) $display("FAIL rand_en_count: got %0d expected %0d", en_cnt - en_base, exp_q.size()); else pass_cnt++;
      chk_cnt++; if (err_cnt - err_base != exp_err) $display("FAIL rand_err_count: got %0d expected %0d", err_cnt - err_base, exp_err); else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
         chk_cnt++;
         if (got_q.size() <= got_base + i) $display("FAIL rand_byte%0d: got none expected %h", i, exp_q[i]);
         else if (got_q[got_base+i] !== exp_q[i]) $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[got_base+i], exp_q[i]);
         else pass_cnt++;
      end
      chk_cnt++; if (uart_data !== last_good) $display("FAIL rand_data_hold: got %h expected %h", uart_data, last_good); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid_frame();
      test_break();
      test_random();
      chk_cnt++; if (both_cnt != 0) $display("FAIL pulse_overlap: got %0d expected 0", both_cnt); else pass_cnt++;
      chk_cnt++; if (wide_cnt != 0) $display("FAIL pulse_width: got %0d wide pulses expected 0", wide_cnt); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
